// File: rtl/shift_arb.sv
// shift_arb: round-robin arbiter/sequencer that shares one combinational 8-bit
// barrel shifter between two requesters and returns tagged results.
// Optional feature macro: ROTATE_EN (two-pass rotate via a second shifter pass).
module shift_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_din,
  input  logic [5:0]  req_shamt,
  input  logic [1:0]  req_dir,
  input  logic [1:0]  req_tp,
  input  logic [1:0]  req_rot,
  output logic [7:0]  sh_din,
  output logic [2:0]  sh_shamt,
  output logic        sh_dir,
  output logic        sh_tp,
  input  logic [7:0]  sh_dout,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_dout,
  input  logic        rsp_ready
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          id_q, id_d;
  logic [DW-1:0] acc_q, acc_d;

  logic [DW-1:0] sh_din_d;
  logic [SW-1:0] sh_shamt_d;
  logic          sh_dir_d, sh_tp_d;
  logic          rsp_valid_d, rsp_id_d;
  logic [DW-1:0] rsp_dout_d;

  logic          gnt;
  logic [DW-1:0] sel_din;
  logic [SW-1:0] sel_shamt;
  logic          sel_dir, sel_tp;

`ifdef ROTATE_EN
  logic          sel_rot;
  logic [DW-1:0] din_q, din_d;
  logic [SW-1:0] shamt_q, shamt_d;
  logic          dir_q, dir_d;
  logic          rot_q, rot_d;

  assign sel_rot = req_rot[gnt];
`else
  logic          unused_rot;

  assign unused_rot = ^req_rot;
`endif

  // Round-robin grant and operand select for the winning requester
  always_comb begin
    gnt       = req_valid[prio_q] ? prio_q : ~prio_q;
    sel_din   = gnt ? req_din[15:8]  : req_din[7:0];
    sel_shamt = gnt ? req_shamt[5:3] : req_shamt[2:0];
    sel_dir   = req_dir[gnt];
    sel_tp    = req_tp[gnt];
  end

  // Next-state, handshake and next-output decode
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    acc_d       = acc_q;
    sh_din_d    = '0;
    sh_shamt_d  = '0;
    sh_dir_d    = 1'b0;
    sh_tp_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = 1'b0;
    rsp_dout_d  = '0;
    req_ready   = 2'b00;
`ifdef ROTATE_EN
    din_d       = din_q;
    shamt_d     = shamt_q;
    dir_d       = dir_q;
    rot_d       = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rst && (req_valid != 2'b00)) begin
          req_ready  = gnt ? 2'b10 : 2'b01;
          prio_d     = ~gnt;
          id_d       = gnt;
          sh_din_d   = sel_din;
          sh_shamt_d = sel_shamt;
          sh_dir_d   = sel_dir;
          sh_tp_d    = sel_tp;
`ifdef ROTATE_EN
          // Rotates build from two logical shifts, so the first pass is logical too
          if (sel_rot) sh_tp_d = 1'b1;
          din_d   = sel_din;
          shamt_d = sel_shamt;
          dir_d   = sel_dir;
          rot_d   = sel_rot;
`endif
          state_d = PASS1;
        end
      end
      PASS1: begin
        acc_d       = sh_dout;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_dout_d  = sh_dout;
`ifdef ROTATE_EN
        if (rot_q && (shamt_q != '0)) begin
          state_d     = PASS2;
          rsp_valid_d = 1'b0;
          rsp_id_d    = 1'b0;
          rsp_dout_d  = '0;
          sh_din_d    = din_q;
          // 3-bit wrap of 0 - n equals 8 - n for n in 1..7
          sh_shamt_d  = 3'd0 - shamt_q;
          sh_dir_d    = ~dir_q;
          sh_tp_d     = 1'b1;
        end
`endif
      end
`ifdef ROTATE_EN
      PASS2: begin
        acc_d       = acc_q | sh_dout;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_dout_d  = acc_q | sh_dout;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_dout_d  = acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      id_q      <= 1'b0;
      acc_q     <= '0;
      sh_din    <= '0;
      sh_shamt  <= '0;
      sh_dir    <= 1'b0;
      sh_tp     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_dout  <= '0;
`ifdef ROTATE_EN
      din_q     <= '0;
      shamt_q   <= '0;
      dir_q     <= 1'b0;
      rot_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      id_q      <= id_d;
      acc_q     <= acc_d;
      sh_din    <= sh_din_d;
      sh_shamt  <= sh_shamt_d;
      sh_dir    <= sh_dir_d;
      sh_tp     <= sh_tp_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_dout  <= rsp_dout_d;
`ifdef ROTATE_EN
      din_q     <= din_d;
      shamt_q   <= shamt_d;
      dir_q     <= dir_d;
      rot_q     <= rot_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_arb.sv
// tb_shift_arb: randomized scoreboard bench for shift_arb with a behavioural
// shifter on the sh_* port and a reference model of arbitration and results.
module tb_shift_arb;

  typedef struct packed {
    logic [7:0] din;
    logic [2:0] shamt;
    logic       dir;
    logic       tp;
    logic       rot;
    logic [1:0] gap;
  } cmd_t;

  typedef struct packed {
    logic       id;
    logic [7:0] dout;
    int         lat;
    int         acc_cyc;
  } exp_t;

`ifdef ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid, req_ready, req_dir, req_tp, req_rot;
  logic [15:0] req_din;
  logic [5:0]  req_shamt;
  logic [7:0]  din0, din1;
  logic [2:0]  sa0, sa1;
  logic [7:0]  sh_din, sh_dout;
  logic [2:0]  sh_shamt;
  logic        sh_dir, sh_tp;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [7:0]  rsp_dout;

  assign req_din   = {din1, din0};
  assign req_shamt = {sa1, sa0};

  shift_arb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_din(req_din),
    .req_shamt(req_shamt), .req_dir(req_dir), .req_tp(req_tp), .req_rot(req_rot),
    .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_dir(sh_dir), .sh_tp(sh_tp),
    .sh_dout(sh_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_dout(rsp_dout), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared barrel shifter
  always_comb begin
    if (sh_dir)     sh_dout = sh_din << sh_shamt;
    else if (sh_tp) sh_dout = sh_din >> sh_shamt;
    else            sh_dout = 8'($signed(sh_din) >>> sh_shamt);
  end

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  int   rr_mode = 1;
  cmd_t cmd_q0[$], cmd_q1[$];
  exp_t exp_q[$];
  logic grant_log[$];
  logic       last_served;
  logic [7:0] last_dout;
  logic       last_id;
  int         last_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the operation's definition
  function automatic logic [7:0] ref_result(input cmd_t c);
    int x, n, s;
    x = int'(c.din);
    n = int'(c.shamt);
    if (ROT_EN && c.rot) begin
      if (c.dir) return 8'((x << n) | (x >> (8 - n)));
      return 8'((x >> n) | (x << (8 - n)));
    end
    if (c.dir) return 8'(x << n);
    if (c.tp)  return 8'(x >> n);
    s = c.din[7] ? x - 256 : x;
    return 8'(s >>> n);
  endfunction

  function automatic int ref_latency(input cmd_t c);
    return (ROT_EN && c.rot && (c.shamt != 3'd0)) ? 3 : 2;
  endfunction

  // Requester driver: presents queued commands, scrambles inputs after accept
  initial begin : drv
    cmd_t       cur [2];
    bit         have [2];
    int         wt [2];
    logic [7:0] d [2];
    logic [2:0] s [2];
    logic [1:0] tk;
    req_valid = '0; req_dir = '0; req_tp = '0; req_rot = '0;
    din0 = '0; din1 = '0; sa0 = '0; sa1 = '0;
    for (int i = 0; i < 2; i++) begin
      have[i] = 1'b0; wt[i] = 0; d[i] = '0; s[i] = '0;
    end
    forever begin
      @(negedge clk);
      tk = rst ? 2'b00 : (req_valid & req_ready);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (tk[i]) begin
          req_valid[i] = 1'b0;
          d[i] = 8'($urandom); s[i] = 3'($urandom);
          req_dir[i] = 1'($urandom); req_tp[i] = 1'($urandom); req_rot[i] = 1'($urandom);
        end
        if (!req_valid[i]) begin
          if (!have[i]) begin
            if (i == 0 && cmd_q0.size() > 0) begin
              cur[i] = cmd_q0.pop_front(); have[i] = 1'b1; wt[i] = int'(cur[i].gap);
            end else if (i == 1 && cmd_q1.size() > 0) begin
              cur[i] = cmd_q1.pop_front(); have[i] = 1'b1; wt[i] = int'(cur[i].gap);
            end
          end
          if (have[i]) begin
            if (wt[i] == 0) begin
              req_valid[i] = 1'b1;
              d[i] = cur[i].din; s[i] = cur[i].shamt;
              req_dir[i] = cur[i].dir; req_tp[i] = cur[i].tp; req_rot[i] = cur[i].rot;
              have[i] = 1'b0;
            end else begin
              wt[i]--;
            end
          end
        end
      end
      din0 = d[0]; din1 = d[1]; sa0 = s[0]; sa1 = s[1];
    end
  end

  // Response-ready driver
  initial begin : rr_drv
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Accept side: expected grant, idle outputs, push expected responses
  initial begin : acc_mon
    logic       g;
    logic [1:0] er;
    cmd_t       c;
    exp_t       e;
    last_served = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_served = 1'b1;
        exp_q.delete();
      end else if (exp_q.size() == 0) begin
        er = 2'b00;
        g  = 1'b0;
        if (req_valid != 2'b00) begin
          g  = (req_valid == 2'b11) ? ~last_served : req_valid[1];
          er = g ? 2'b10 : 2'b01;
        end
        check("req_ready_idle", 32'(req_ready), 32'(er));
        check("idle_outputs", 32'({sh_din, sh_shamt, sh_dir, sh_tp, rsp_valid, rsp_id, rsp_dout}), 32'd0);
        if (er != 2'b00 && req_ready == er) begin
          c.din   = g ? req_din[15:8] : req_din[7:0];
          c.shamt = g ? req_shamt[5:3] : req_shamt[2:0];
          c.dir   = req_dir[g];
          c.tp    = req_tp[g];
          c.rot   = req_rot[g];
          c.gap   = 2'd0;
          e.id      = g;
          e.dout    = ref_result(c);
          e.lat     = ref_latency(c);
          e.acc_cyc = cyc;
          exp_q.push_back(e);
          grant_log.push_back(g);
          last_served = g;
        end
      end else begin
        check("req_ready_busy", 32'(req_ready), 32'd0);
      end
    end
  end

  // Response side: pop and compare whenever the DUT presents a response
  initial begin : rsp_mon
    exp_t e;
    bit   first;
    int   lat;
    first = 1'b1;
    lat   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        first = 1'b1;
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: actual id %0d dout 0x%0h, required no response", rsp_id, rsp_dout);
        end else begin
          e = exp_q[0];
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_dout", 32'(rsp_dout), 32'(e.dout));
          if (first) begin
            lat = cyc - e.acc_cyc;
            check("rsp_latency", 32'(lat), 32'(e.lat));
          end
          first = 1'b0;
          if (rsp_ready) begin
            last_dout = rsp_dout;
            last_id   = rsp_id;
            last_lat  = lat;
            @(posedge clk);
            e = exp_q.pop_front();
            n_done++;
            first = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_done(input int n);
    int target;
    int budget;
    target = n_done + n;
    budget = n * 20 + 50;
    while (n_done < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (n_done < target) check("completion_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic push_cmd(input int r, input cmd_t c);
    if (r == 0) cmd_q0.push_back(c);
    else        cmd_q1.push_back(c);
  endtask

  task automatic one(input int r, input logic [7:0] din, input logic [2:0] n, input logic dir,
                     input logic tp, input logic rot, input logic [7:0] ed, input int el,
                     input string name);
    cmd_t c;
    c = '{din: din, shamt: n, dir: dir, tp: tp, rot: rot, gap: 2'd0};
    @(negedge clk);
    push_cmd(r, c);
    wait_done(1);
    check({name, "_dout"}, 32'(last_dout), 32'(ed));
    check({name, "_id"}, 32'(last_id), 32'(r));
    check({name, "_lat"}, 32'(last_lat), 32'(el));
  endtask

  task automatic contend(input int n);
    cmd_t c;
    int   gb;
    @(negedge clk);
    gb = grant_log.size();
    for (int k = 0; k < n; k++) begin
      c = '{din: 8'($urandom), shamt: 3'($urandom), dir: 1'($urandom),
            tp: 1'($urandom), rot: 1'b0, gap: 2'd0};
      cmd_q0.push_back(c);
      c.din = 8'($urandom);
      cmd_q1.push_back(c);
    end
    wait_done(2 * n);
    for (int k = 0; k < 2 * n; k++) begin
      if (gb + k < grant_log.size()) check("grant_order", 32'(grant_log[gb + k]), 32'(k % 2));
      else check("grant_count", 32'(grant_log.size()), 32'(gb + 2 * n));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    cmd_t c;
    int   cnt;
    int   budget;
    rr_mode = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          32'({req_ready, sh_din, sh_shamt, sh_dir, sh_tp, rsp_valid, rsp_id, rsp_dout}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    contend(4);

    one(0, 8'h96, 3'd2, 1'b1, 1'b0, 1'b0, 8'h58, 2, "shl");
    one(1, 8'h96, 3'd1, 1'b0, 1'b0, 1'b0, 8'hCB, 2, "shr_arith");
    one(1, 8'h96, 3'd1, 1'b0, 1'b1, 1'b0, 8'h4B, 2, "shr_logic");
`ifdef ROTATE_EN
    one(0, 8'h96, 3'd3, 1'b1, 1'b0, 1'b1, 8'hB4, 3, "rotl");
    one(0, 8'h96, 3'd3, 1'b0, 1'b0, 1'b1, 8'hD2, 3, "rotr");
    one(1, 8'h96, 3'd0, 1'b1, 1'b0, 1'b1, 8'h96, 2, "rot0");
`else
    one(0, 8'h96, 3'd3, 1'b1, 1'b0, 1'b1, 8'hB0, 2, "rot_ignored");
`endif

    // Backpressure with the other requester waiting
    rr_mode = 2;
    @(negedge clk);
    c = '{din: 8'h3C, shamt: 3'd5, dir: 1'b0, tp: 1'b0, rot: 1'b1, gap: 2'd0};
    cmd_q0.push_back(c);
    c = '{din: 8'hA5, shamt: 3'd4, dir: 1'b1, tp: 1'b1, rot: 1'b0, gap: 2'd0};
    cmd_q1.push_back(c);
    budget = 20;
    while (!rsp_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(rsp_valid), 32'd1);
      check("bp_ready_low", 32'(req_ready), 32'd0);
    end
    rr_mode = 1;
    wait_done(2);

    // Reset during PASS1 aborts the transaction
    @(negedge clk);
    c = '{din: 8'h81, shamt: 3'd1, dir: 1'b1, tp: 1'b0, rot: 1'b0, gap: 2'd0};
    cmd_q0.push_back(c);
    budget = 20;
    while (!(req_valid[0] && req_ready[0]) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("abort_accept_seen", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outputs",
          32'({req_ready, sh_din, sh_shamt, sh_dir, sh_tp, rsp_valid, rsp_id, rsp_dout}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("abort_no_rsp", 32'(cnt), 32'd0);

    contend(2);

    // Randomized traffic with random backpressure
    rr_mode = 0;
    @(negedge clk);
    for (int k = 0; k < 150; k++) begin
      c.din   = 8'($urandom);
      c.shamt = 3'($urandom);
      c.dir   = 1'($urandom);
      c.tp    = 1'($urandom);
      c.rot   = 1'($urandom);
      c.gap   = 2'($urandom);
      push_cmd($urandom_range(0, 1), c);
    end
    wait_done(150);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_arb.md
# shift_arb

Round-robin arbiter and sequencer sharing one combinational 8-bit barrel shifter between two requesters. It accepts shift commands over valid/ready handshakes and drives the shared shifter's operand inputs from registered operands. It captures the shifter result and returns it on a single tagged response channel. It sits between the two client datapaths and the shifter instance; optionally it sequences two shifter passes to implement rotates.

## Interface
- Parameters: none. Datapath is fixed at 8 bits with 2 requesters.
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  2  per-requester command valid; bit i = requester i
- req_ready  out  2  per-requester accept
- req_din  in  16  operands {r1[7:0], r0[7:0]}
- req_shamt  in  6  shift amounts {r1[2:0], r0[2:0]}
- req_dir  in  2  1 = left, 0 = right
- req_tp  in  2  right shifts only: 1 = logical, 0 = arithmetic
- req_rot  in  2  1 = rotate (see Configuration)
- sh_din  out  8  to shifter din
- sh_shamt  out  3  to shifter shamt
- sh_dir  out  1  to shifter dir
- sh_tp  out  1  to shifter tp
- sh_dout  in  8  from shifter dout; combinational in current sh_* values
- rsp_valid  out  1  response valid
- rsp_id  out  1  requester index of the response
- rsp_dout  out  8  result
- rsp_ready  in  1  response accept

## Operation
- States: IDLE, PASS1, PASS2, RESP.
- IDLE:
  - Grant uses round-robin pointer `prio`. The requester `prio` wins if valid; otherwise the other requester wins if valid.
  - req_ready[g] = 1 only for the granted requester g, and only in IDLE. Never both bits set.
  - On req_valid[g] & req_ready[g], latch din, shamt, dir, tp, rot and id = g; set prio = ~g; go to PASS1.
- PASS1:
  - Drive sh_* from the latched operands and capture sh_dout into acc.
  - Go to PASS2 if the op is a rotate and shamt != 0; otherwise go to RESP.
- PASS2 (rotate only): drive sh_din = latched din, sh_shamt = 8 - shamt (3-bit, 1..7), sh_dir = ~dir, sh_tp = 1; set acc = acc | sh_dout; go to RESP.
- RESP:
  - rsp_valid = 1, rsp_dout = acc, rsp_id = id.
  - Outputs stay stable until rsp_ready; on rsp_valid & rsp_ready go to IDLE.
- Outside PASS1/PASS2, sh_* are driven to 0.
- Rotate semantics:
  - dir = 1: rotate left = (din << n) | (din >> (8 - n)).
  - dir = 0: rotate right = (din >> n) | (din << (8 - n)). PASS1 uses tp = 1 (logical) regardless of the req_tp value.
  - n = 0 is a single pass and returns din.
- Reset values: state IDLE, prio 0, acc 0, latched operands 0. All outputs are 0: req_ready, sh_*, rsp_valid, rsp_id, rsp_dout.
- Reset mid-operation aborts the transaction: no response is issued and the requester is not re-acknowledged.

## Timing
- Accept at edge T → PASS1 during cycle T+1 → rsp_valid from cycle T+2 (shift), or from T+3 (rotate, n != 0).
- The response handshake at edge R returns the block to IDLE; the next accept is at edge R+1 at the earliest.
- Peak throughput is one shift per 3 cycles, or one rotate per 4 cycles.
- Simultaneous valid on both requesters: the `prio` requester is served; the other is served next if still valid. No starvation.
- Requester inputs are sampled only at the accept edge; changes in other cycles are ignored.
- rsp_ready held high during RESP completes the response in one cycle.

## Configuration
- ROTATE_EN defined: req_rot is honoured and PASS2 exists as above.
- ROTATE_EN undefined: req_rot is ignored, every op runs PASS1 only, PASS2 is unreachable and may be omitted, and the latency is always 2.

## Test plan
- Shift-left: r0 sends din 0x96, shamt 2, dir 1 → rsp_dout 0x58, rsp_id 0, rsp_valid 2 cycles after accept.
- Right shifts: r1 sends 0x96, shamt 1, dir 0, tp 0 → 0xCB, rsp_id 1. Same with tp 1 → 0x4B.
- Contention after reset: both requesters valid → r0 granted first, r1 granted next. Repeated with both held valid, grants alternate 0,1,0,1.
- Rotate with ROTATE_EN:
  - 0x96, shamt 3, dir 1, rot 1 → 0xB4, latency 3.
  - dir 0 → 0xD2.
  - shamt 0 → 0x96, latency 2.
- Without ROTATE_EN: 0x96, shamt 3, dir 1, rot 1 → 0xB0, latency 2.
- Backpressure and reset: rsp_ready held 0 for 5 cycles → rsp_valid and rsp_dout stay stable and req_ready stays 0. rst asserted during PASS1 → all outputs 0 next cycle and no response is ever produced.
